// File: rtl/line_window_pkg.sv
// ---------------------------------------------------------------------------
// line_window_pkg
// Shared helpers for the vertical line-window buffer.
//   line_addr_w  : address width needed to index one line of pixels
//   col_slice_lo : low bit of row slice 'row' inside a packed column
//                  (row 0 = current row, higher rows are older)
// ---------------------------------------------------------------------------
package line_window_pkg;

  // Address width for a line of 'line_w' pixels. At least one bit so that
  // degenerate sizes still produce a legal vector.
  function automatic int line_addr_w(input int line_w);
    return (line_w > 1) ? $clog2(line_w) : 1;
  endfunction

  // Bit position of the lowest bit of row slice 'row' in a column whose
  // slices are 'width' bits wide.
  function automatic int col_slice_lo(input int row, input int width);
    return row * width;
  endfunction

endpackage

// File: rtl/line_bank.sv
// ---------------------------------------------------------------------------
// line_bank
// One line of pixel storage: 1 write port, 1 read port, registered read.
//   clk_i     : clock, rising edge
//   clr_i     : synchronous active-high clear of the read register only
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe; read register holds its value while low
//   rd_addr_i : read address
//   rd_data_o : registered read data
// The storage array itself is never cleared.
// ---------------------------------------------------------------------------
module line_bank #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  parameter int ADDR_W  = 10
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [WIDTH_P-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [WIDTH_P-1:0] rd_data_o
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  // Plain write port; contents survive reset so the array can map to RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read. Holding the value while rd_en_i is low is what keeps
  // the downstream column stable during a stall.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
// Streaming vertical-window line buffer. For every accepted raster pixel it
// emits the column of LINES_P pixels at that x position, once enough rows
// have been seen to fill the column.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   valid_i / ready_o / data_i / sof_i : pixel input handshake; sof_i marks
//             the pixel at (x=0, y=0)
//   valid_o / ready_i / data_o / eol_o : column output handshake; data_o
//             bits [WIDTH_P-1:0] are the current row, the top slice is the
//             oldest row; eol_o flags the column at x = LINE_W_P-1
// ---------------------------------------------------------------------------
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640,
  parameter int LINES_P  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH_P-1:0]         data_i,
  input  logic                       sof_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LINES_P*WIDTH_P-1:0] data_o,
  output logic                       eol_o
);

  localparam int ADDR_W = line_addr_w(LINE_W_P);
  localparam int BANKS  = LINES_P - 1;
  localparam int Y_W    = $clog2(LINES_P);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(LINE_W_P - 1);
  localparam logic [Y_W-1:0]    Y_FULL = Y_W'(LINES_P - 1);

  typedef logic [WIDTH_P-1:0] pixel_t;

  logic [ADDR_W-1:0] x_q;
  logic [ADDR_W-1:0] x_cur;
  logic [Y_W-1:0]    y_q;
  logic [Y_W-1:0]    y_cur;

  logic              p1_valid;
  logic              p1_last;
  logic              p1_row_ok;
  pixel_t            p1_pixel;
  logic [ADDR_W-1:0] p1_x;

  logic              accept;
  logic              retire;
  logic              wr_en;

  pixel_t            bank_rd [BANKS];
  pixel_t            bank_wr [BANKS];

  // Warm-up entries never wait for downstream; real columns need ready_i.
  assign retire  = p1_valid && (!p1_row_ok || ready_i);
  assign ready_o = !rst_i && (!p1_valid || retire);
  assign accept  = valid_i && ready_o;

  // sof_i overrides the running position so a frame can restart anywhere.
  assign x_cur = sof_i ? '0 : x_q;
  assign y_cur = sof_i ? '0 : y_q;

  // A retire that lands on the reset edge is dropped.
  assign wr_en = retire && !rst_i;

  assign valid_o = p1_valid && p1_row_ok;
  assign eol_o   = valid_o && p1_last;

  // Raster position. y only needs to count up to "enough rows", so it
  // saturates rather than tracking the full frame height.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_cur == X_LAST) begin
        x_q <= '0;
        y_q <= (y_cur == Y_FULL) ? y_cur : y_cur + Y_W'(1);
      end else begin
        x_q <= x_cur + ADDR_W'(1);
        y_q <= y_cur;
      end
    end
  end

  // P1 stage: the pixel whose column is currently being presented. It
  // carries its own x so the shift-write lands where the read came from.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_valid  <= 1'b0;
      p1_pixel  <= '0;
      p1_x      <= '0;
      p1_last   <= 1'b0;
      p1_row_ok <= 1'b0;
    end else if (accept) begin
      p1_valid  <= 1'b1;
      p1_pixel  <= data_i;
      p1_x      <= x_cur;
      p1_last   <= (x_cur == X_LAST);
      p1_row_ok <= (y_cur == Y_FULL);
    end else if (retire) begin
      p1_valid  <= 1'b0;
    end
  end

  // Shift-write data: each bank takes what the bank below it returned for
  // this x, so the rows age by one as the column retires.
  always_comb begin
    for (int k = 0; k < BANKS; k++) begin
      bank_wr[k] = (k == 0) ? p1_pixel : bank_rd[(k == 0) ? 0 : k - 1];
    end
  end

  // Column assembly: current pixel in the low slice, older rows above it.
  always_comb begin
    data_o = '0;
    data_o[WIDTH_P-1:0] = p1_pixel;
    for (int k = 0; k < BANKS; k++) begin
      data_o[col_slice_lo(k + 1, WIDTH_P) +: WIDTH_P] = bank_rd[k];
    end
  end

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    line_bank #(
      .WIDTH_P (WIDTH_P),
      .DEPTH_P (LINE_W_P),
      .ADDR_W  (ADDR_W)
    ) u_bank (
      .clk_i     (clk_i),
      .clr_i     (rst_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (p1_x),
      .wr_data_i (bank_wr[k]),
      .rd_en_i   (accept),
      .rd_addr_i (x_cur),
      .rd_data_o (bank_rd[k])
    );
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_window_buffer
// Directed bench for line_window_buffer with WIDTH_P=8, LINE_W_P=4,
// LINES_P=3. Pixel value is 16*y + x (new frame in the sof scenario adds
// 0x80). A frame model predicts every column; hand-computed constants pin
// down the key columns.
// ---------------------------------------------------------------------------
module tb_line_window_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  data_i = '0;
  logic        sof_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [23:0] data_o;
  logic        eol_o;

  int errors = 0;
  int checks = 0;

  // Frame model state
  logic [7:0]  cur_line [4] = '{default: 8'h00};
  logic [7:0]  line1    [4] = '{default: 8'h00};
  logic [7:0]  line2    [4] = '{default: 8'h00};
  int          mx = 0;
  int          my = 0;
  logic [24:0] exp_q [$];
  logic [24:0] out_log [$];
  bit          last_acc;

  logic [24:0] a_exp [8] = '{25'h0001020, 25'h0011121, 25'h0021222, 25'h1031323,
                             25'h0102030, 25'h0112131, 25'h0122232, 25'h1132333};

  line_window_buffer #(
    .WIDTH_P  (8),
    .LINE_W_P (4),
    .LINES_P  (3)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .sof_i   (sof_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .eol_o   (eol_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Frame model: tracks position and the two previous rows.
  task automatic modelAccept(input logic [7:0] pix, input logic sof);
    if (sof) begin
      mx = 0;
      my = 0;
    end
    if (my >= 2) exp_q.push_back({(mx == 3), line2[mx], line1[mx], pix});
    cur_line[mx] = pix;
    if (mx == 3) begin
      mx = 0;
      line2 = line1;
      line1 = cur_line;
      if (my < 1000) my++;
    end else begin
      mx++;
    end
  endtask

  // One clock cycle: drive after the edge, sample at the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] pix, input logic sof,
                               input logic rdy, input logic rst);
    @(posedge clk_i);
    #1;
    rst_i   = rst;
    valid_i = v;
    data_i  = pix;
    sof_i   = sof;
    ready_i = rdy;
    @(negedge clk_i);
    last_acc = 1'b0;
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        checkOutput("column", 32'(data_o), 32'(exp_q[0][23:0]));
        checkOutput("eol", 32'(eol_o), 32'(exp_q[0][24]));
        if (ready_i) begin
          out_log.push_back({eol_o, data_o});
          void'(exp_q.pop_front());
        end
      end
    end
    if (valid_i && ready_o) begin
      last_acc = 1'b1;
      modelAccept(data_i, sof_i);
    end
    if (rst) begin
      exp_q.delete();
      mx = 0;
      my = 0;
    end
  endtask

  // Offer one pixel until accepted, optionally with random gaps and stalls.
  task automatic sendPixel(input logic [7:0] pix, input logic sof, input bit rnd);
    int  n;
    logic v;
    logic r;
    n = 0;
    do begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(v, pix, sof, r, 1'b0);
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendRow(input int y, input logic [7:0] base, input bit sof_first, input bit rnd);
    for (int x = 0; x < 4; x++) begin
      sendPixel(8'(base + 16 * y + x), sof_first && (x == 0), rnd);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base_idx;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_valid_o", 32'(valid_o), 32'd0);
    checkOutput("rst_data_o", 32'(data_o), 32'd0);
    checkOutput("rst_eol_o", 32'(eol_o), 32'd0);
    checkOutput("rst_ready_o", 32'(ready_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_ready_o", 32'(ready_o), 32'd1);

    // Warm-up, first column, full-rate row 3
    $display("[TB] warm-up and full-rate column check");
    sendRow(0, 8'h00, 1'b1, 1'b0);
    sendRow(1, 8'h00, 1'b0, 1'b0);
    sendPixel(8'h20, 1'b0, 1'b0);
    sendPixel(8'h21, 1'b0, 1'b0);
    checkOutput("first_col_valid", 32'(valid_o), 32'd1);
    checkOutput("first_col_data", 32'(data_o), 32'h001020);
    sendPixel(8'h22, 1'b0, 1'b0);
    sendPixel(8'h23, 1'b0, 1'b0);
    sendRow(3, 8'h00, 1'b0, 1'b0);
    drain(3);
    checkOutput("a_count", 32'(out_log.size()), 32'd8);
    if (out_log.size() == 8) begin
      for (int i = 0; i < 8; i++) checkOutput("a_table", 32'(out_log[i]), 32'(a_exp[i]));
    end

    // Backpressure mid-row 3
    $display("[TB] backpressure");
    base_idx = out_log.size();
    sendRow(0, 8'h00, 1'b1, 1'b0);
    sendRow(1, 8'h00, 1'b0, 1'b0);
    sendRow(2, 8'h00, 1'b0, 1'b0);
    sendPixel(8'h30, 1'b0, 1'b0);
    sendPixel(8'h31, 1'b0, 1'b0);
    sendPixel(8'h32, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_ready_o", 32'(ready_o), 32'd0);
      checkOutput("stall_valid_o", 32'(valid_o), 32'd1);
      checkOutput("stall_data_o", 32'(data_o), 32'h122232);
    end
    sendPixel(8'h33, 1'b0, 1'b0);
    drain(3);
    checkOutput("b_count", 32'(out_log.size() - base_idx), 32'd8);
    if (out_log.size() == base_idx + 8) begin
      checkOutput("b_after_stall", 32'(out_log[base_idx + 6]), 32'h0122232);
      checkOutput("b_last", 32'(out_log[base_idx + 7]), 32'h1132333);
    end

    // Random valid/ready over 6 rows
    $display("[TB] random stall");
    base_idx = out_log.size();
    for (int y = 0; y < 6; y++) sendRow(y, 8'h00, (y == 0), 1'b1);
    drain(6);
    checkOutput("c_count", 32'(out_log.size() - base_idx), 32'd16);

    // Mid-frame sof at row 3, x=2
    $display("[TB] mid-frame sof");
    for (int y = 0; y < 3; y++) sendRow(y, 8'h00, (y == 0), 1'b0);
    sendPixel(8'h30, 1'b0, 1'b0);
    sendPixel(8'h31, 1'b0, 1'b0);
    sendRow(0, 8'h80, 1'b1, 1'b0);
    sendRow(1, 8'h80, 1'b0, 1'b0);
    base_idx = out_log.size();
    sendRow(2, 8'h80, 1'b0, 1'b0);
    drain(3);
    checkOutput("d_count", 32'(out_log.size() - base_idx), 32'd4);
    if (out_log.size() == base_idx + 4) begin
      checkOutput("d_first_new", 32'(out_log[base_idx]), 32'h08090A0);
      checkOutput("d_last_new", 32'(out_log[base_idx + 3]), 32'h18393A3);
    end

    // Reset with P1 full and a stall pending
    $display("[TB] reset mid-operation");
    for (int y = 0; y < 3; y++) sendRow(y, 8'h00, (y == 0), 1'b0);
    sendPixel(8'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    checkOutput("e_stalled_valid", 32'(valid_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("e_rst_valid_o", 32'(valid_o), 32'd0);
    checkOutput("e_rst_data_o", 32'(data_o), 32'd0);
    checkOutput("e_rst_ready_o", 32'(ready_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("e_post_rst_ready", 32'(ready_o), 32'd1);
    base_idx = out_log.size();
    sendRow(0, 8'h00, 1'b0, 1'b0);
    sendRow(1, 8'h00, 1'b0, 1'b0);
    sendPixel(8'h20, 1'b0, 1'b0);
    sendPixel(8'h21, 1'b0, 1'b0);
    checkOutput("e_first_col_valid", 32'(valid_o), 32'd1);
    checkOutput("e_first_col_data", 32'(data_o), 32'h001020);
    sendPixel(8'h22, 1'b0, 1'b0);
    sendPixel(8'h23, 1'b0, 1'b0);
    drain(3);
    checkOutput("e_count", 32'(out_log.size() - base_idx), 32'd4);
    if (out_log.size() == base_idx + 4) begin
      checkOutput("e_eol_col", 32'(out_log[base_idx + 3]), 32'h1031323);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
